// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine between the CPU core and the system bus.
// A CPU write to DMA_REG_ADDR latches a source page, halts the CPU via
// cpu_rdy and copies 256 bytes from {page,00..FF} to OAM_DATA_ADDR as
// read/write pairs. When idle, CPU bus signals pass straight through.
//
// Ports:
//   clk_ph2   - CPU bus clock (rising edge)
//   rst       - asynchronous active-high reset
//   cpu_addr  - CPU address bus
//   cpu_dout  - CPU write data
//   cpu_we    - CPU write strobe
//   cpu_rdy   - CPU ready, 0 halts the CPU
//   bus_din   - read data from the system bus
//   bus_addr  - system bus address (CPU or DMA)
//   bus_dout  - system bus write data
//   bus_we    - system bus write strobe
//
// Optional feature macro OAM_DMA_DBG_EN adds:
//   dma_active_dbg - high while a transfer is in progress
//   dma_idx_dbg    - current transfer index
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk_ph2,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we
`ifdef OAM_DMA_DBG_EN
    ,
    output logic        dma_active_dbg,
    output logic [7:0]  dma_idx_dbg
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic [7:0] index;
    logic [7:0] page;
    logic [7:0] latch;
    // parity=0 marks a "get" cycle; reads must land on those
    logic       parity;

    always_ff @(posedge clk_ph2 or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cpu_rdy <= 1'b1;
            index   <= 8'd0;
            page    <= 8'd0;
            latch   <= 8'd0;
            parity  <= 1'b0;
        end else begin
            parity <= ~parity;
            unique case (state)
                IDLE: begin
                    if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
                        page    <= cpu_dout;
                        index   <= 8'd0;
                        cpu_rdy <= 1'b0;
                        state   <= HALT;
                    end
                end
                // next cycle's parity is ~parity; READ only if it is 0
                HALT: state <= parity ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    latch <= bus_din;
                    state <= WRITE;
                end
                WRITE: begin
                    if (index == LAST_IDX) begin
                        cpu_rdy <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        index <= index + 8'd1;
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Index is 8 bits and never carries into the page byte.
    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        unique case (state)
            READ: begin
                bus_addr = {page, index};
                bus_dout = latch;
                bus_we   = 1'b0;
            end
            WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_dout = latch;
                bus_we   = 1'b1;
            end
            default: begin
                bus_addr = cpu_addr;
                bus_dout = cpu_dout;
                bus_we   = cpu_we;
            end
        endcase
    end

`ifdef OAM_DMA_DBG_EN
    assign dma_active_dbg = (state != IDLE);
    assign dma_idx_dbg    = index;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized self-checking bench for oam_dma.
// Expected bus traffic is built from the transfer rules in a queue model.
module tb_oam_dma;

    logic        clk_ph2 = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h8000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy;
    logic [7:0]  bus_din;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_we;
`ifdef OAM_DMA_DBG_EN
    logic        dma_active_dbg;
    logic [7:0]  dma_idx_dbg;
`endif

    oam_dma dut (
        .clk_ph2  (clk_ph2),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .cpu_rdy  (cpu_rdy),
        .bus_din  (bus_din),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_we   (bus_we)
`ifdef OAM_DMA_DBG_EN
        ,
        .dma_active_dbg (dma_active_dbg),
        .dma_idx_dbg    (dma_idx_dbg)
`endif
    );

    always #5 clk_ph2 = ~clk_ph2;

    logic [7:0] mem [0:65535];
    assign bus_din = mem[bus_addr];

    // cycles since reset; bit 0 is the bus parity of the current cycle
    int unsigned cyc;
    always @(posedge clk_ph2 or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  dout;
        logic        par;
    } bus_t;

    bus_t rec[$];
    int   low_cnt;

    task automatic go_parity(input logic want);
        @(posedge clk_ph2); #1;
        for (int k = 0; k < 4 && cyc[0] !== want; k++) begin
            @(posedge clk_ph2); #1;
        end
    endtask

    task automatic run_dma(input string name, input logic [7:0] page,
                           input logic want, input int inject_at);
        bus_t e;
        bus_t exp_q[$];
        int   pass_n, bad, first, rbad;
        go_parity(want);
        cpu_addr = 16'h4014;
        cpu_dout = page;
        cpu_we   = 1'b1;
        @(negedge clk_ph2);
        checks++;
        if (bus_addr !== 16'h4014 || bus_we !== 1'b1 ||
            bus_dout !== page || cpu_rdy !== 1'b1) begin
            fails++;
            $display("FAIL %s trigger: addr=%h we=%b dout=%h rdy=%b want addr=4014 we=1 dout=%h rdy=1",
                     name, bus_addr, bus_we, bus_dout, cpu_rdy, page);
        end
        @(posedge clk_ph2); #1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
        rec.delete();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_ph2);
            if (cpu_rdy === 1'b1) break;
            e.addr = bus_addr;
            e.we   = bus_we;
            e.dout = bus_dout;
            e.par  = cyc[0];
            rec.push_back(e);
            if (n == inject_at) begin
                cpu_we   = 1'b1;
                cpu_addr = 16'h4014;
                cpu_dout = 8'h07;
            end else if (n == inject_at + 1) begin
                cpu_we   = 1'b0;
                cpu_addr = 16'h8000;
                cpu_dout = 8'h00;
            end
        end
        low_cnt = rec.size();

        // model: halt cycles, then 256 read/write pairs
        pass_n = want ? 2 : 1;
        for (int k = 0; k < pass_n; k++) begin
            e = '0;
            e.addr = 16'h8000;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 256; i++) begin
            e = '0;
            e.addr = {page, 8'(i)};
            exp_q.push_back(e);
            e.addr = 16'h2004;
            e.we   = 1'b1;
            e.dout = mem[{page, 8'(i)}];
            exp_q.push_back(e);
        end

        checks++;
        if (low_cnt !== exp_q.size()) begin
            fails++;
            $display("FAIL %s rdy_low: got %0d cycles want %0d",
                     name, low_cnt, exp_q.size());
        end

        bad = 0;
        first = -1;
        for (int n = 0; n < low_cnt && n < exp_q.size(); n++) begin
            if (rec[n].addr !== exp_q[n].addr || rec[n].we !== exp_q[n].we ||
                (exp_q[n].we && rec[n].dout !== exp_q[n].dout)) begin
                bad++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL %s sequence: %0d bad cycles, first #%0d got addr=%h we=%b dout=%h want addr=%h we=%b dout=%h",
                     name, bad, first, rec[first].addr, rec[first].we,
                     rec[first].dout, exp_q[first].addr, exp_q[first].we,
                     exp_q[first].dout);
        end

        rbad = 0;
        for (int n = pass_n; n < low_cnt; n++)
            if (rec[n].we === 1'b0 && rec[n].par !== 1'b0) rbad++;
        checks++;
        if (rbad !== 0) begin
            fails++;
            $display("FAIL %s read_parity: %0d reads on parity 1, want 0",
                     name, rbad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #10;
        checks++;
        if (cpu_rdy !== 1'b1 || bus_addr !== 16'h8000 || bus_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b addr=%h we=%b want rdy=1 addr=8000 we=0",
                     cpu_rdy, bus_addr, bus_we);
        end
`ifdef OAM_DMA_DBG_EN
        checks++;
        if (dma_active_dbg !== 1'b0 || dma_idx_dbg !== 8'h00) begin
            fails++;
            $display("FAIL reset_dbg: active=%b idx=%h want 0 00",
                     dma_active_dbg, dma_idx_dbg);
        end
`endif
        @(negedge clk_ph2);
        rst = 1'b0;
        @(posedge clk_ph2); #1;
        cpu_addr = 16'h8000;
        cpu_we   = 1'b0;
        @(negedge clk_ph2);
        checks++;
        if (bus_addr !== 16'h8000 || bus_we !== 1'b0 || cpu_rdy !== 1'b1) begin
            fails++;
            $display("FAIL cpu_read_pass: addr=%h we=%b rdy=%b want 8000 0 1",
                     bus_addr, bus_we, cpu_rdy);
        end
        @(posedge clk_ph2); #1;
        cpu_addr = 16'h0300;
        cpu_dout = 8'h5A;
        cpu_we   = 1'b1;
        @(negedge clk_ph2);
        checks++;
        if (bus_addr !== 16'h0300 || bus_dout !== 8'h5A || bus_we !== 1'b1) begin
            fails++;
            $display("FAIL cpu_write_pass: addr=%h dout=%h we=%b want 0300 5a 1",
                     bus_addr, bus_dout, bus_we);
        end
        @(posedge clk_ph2); #1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
    endtask

    task automatic test_parity0();
        run_dma("par0", 8'h02, 1'b0, -1);
    endtask

    task automatic test_parity1();
        run_dma("par1", 8'h02, 1'b1, -1);
    endtask

    task automatic test_page_ff();
        int zero_hits;
        run_dma("pageff", 8'hFF, $urandom_range(0, 1) == 1, -1);
        zero_hits = 0;
        foreach (rec[n]) if (rec[n].addr === 16'h0000) zero_hits++;
        checks++;
        if (zero_hits !== 0) begin
            fails++;
            $display("FAIL pageff_no_0000: %0d accesses to 0000 want 0",
                     zero_hits);
        end
    endtask

    task automatic test_reset_mid();
        int writes;
        logic hit;
        go_parity(1'b0);
        cpu_addr = 16'h4014;
        cpu_dout = 8'h02;
        cpu_we   = 1'b1;
        @(posedge clk_ph2); #1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
        writes = 0;
        hit = 1'b0;
        for (int n = 0; n < 400 && !hit; n++) begin
            @(negedge clk_ph2);
            if (cpu_rdy === 1'b0 && bus_we === 1'b1 && bus_addr === 16'h2004) begin
                writes++;
                if (writes == 101) hit = 1'b1;
            end
        end
        checks++;
        if (!hit) begin
            fails++;
            $display("FAIL mid_reach_idx100: saw %0d writes want 101", writes);
        end
        cpu_addr = 16'h8123;
        cpu_dout = 8'h3C;
        cpu_we   = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (cpu_rdy !== 1'b1 || bus_addr !== 16'h8123 ||
            bus_we !== 1'b1 || bus_dout !== 8'h3C) begin
            fails++;
            $display("FAIL mid_reset: rdy=%b addr=%h we=%b dout=%h want 1 8123 1 3c",
                     cpu_rdy, bus_addr, bus_we, bus_dout);
        end
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
        @(negedge clk_ph2);
        rst = 1'b0;
        run_dma("restart03", 8'h03, 1'b0, -1);
    endtask

    task automatic idle_watch(input string name);
        int lows;
        lows = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_ph2);
            if (cpu_rdy !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            fails++;
            $display("FAIL %s: rdy low %0d cycles want 0", name, lows);
        end
    endtask

    task automatic test_non_triggers();
        go_parity(1'b0);
        cpu_addr = 16'h4015;
        cpu_dout = 8'h02;
        cpu_we   = 1'b1;
        @(posedge clk_ph2); #1;
        cpu_addr = 16'h4014;
        cpu_we   = 1'b0;
        @(posedge clk_ph2); #1;
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
        idle_watch("no_trigger");
        run_dma("busy_write", 8'h05, $urandom_range(0, 1) == 1, 20);
        idle_watch("no_retrigger");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++)
            run_dma($sformatf("rand%0d", r), 8'($urandom),
                    $urandom_range(0, 1) == 1, -1);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        #2;
        test_reset();
        test_parity0();
        test_parity1();
        test_page_ff();
        test_reset_mid();
        test_non_triggers();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
